arc4_encrypt: RTL and testbench
===============================

# arc4_encrypt

- Produces ARC4 ciphertext: reads a length-prefixed plaintext, XORs each byte with the PRGA keystream, and writes a length-prefixed ciphertext.
- It is the writer end of the ciphertext buffer that the decrypt/crack path reads, and is used to build known ct vectors for the cracker.
- Expects S memory already initialised and key-scheduled by init/ksa.
- Uses the codebase's en/rdy request handshake.

## Interface
Parameters: none.
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  start request, honoured only when rdy=1
- rdy  output  1  high when idle and able to accept en
- s_addr  output  8  S memory address
- s_rddata  input  8  S memory read data, 1-cycle synchronous read
- s_wrdata  output  8  S memory write data
- s_wren  output  1  S memory write enable
- pt_addr  output  8  plaintext memory address; pt[0]=length L, pt[1..L]=bytes
- pt_rddata  input  8  plaintext read data, 1-cycle synchronous read
- ct_addr  output  8  ciphertext memory address
- ct_wrdata  output  8  ciphertext write data
- ct_wren  output  1  ciphertext write enable

## Operation
- Handshake:
  - A request is accepted on a rising edge where rdy=1 and en=1.
  - en while rdy=0 is ignored; there is no queueing.
  - rdy drops on the cycle after acceptance.
- Memory read convention: an address is driven in an RD_* state, and data is sampled at the end of the following GET_* state.
- FSM states and per-state outputs:
  - IDLE: rdy=1.
  - RD_LEN: pt_addr=0.
  - GET_LEN: latch L=pt_rddata.
  - WR_LEN: ct_addr=0, ct_wrdata=L, ct_wren=1. Clear j=0. Set i=1, k=1. If L=0 go to IDLE, else go to RD_SI.
  - RD_SI: s_addr=i.
  - GET_SI: latch si=s_rddata; j <= (j+si) mod 256.
  - RD_SJ: s_addr=j (new value).
  - GET_SJ: latch sj.
  - WR_SI: s_addr=i, s_wrdata=sj, s_wren=1.
  - WR_SJ: s_addr=j, s_wrdata=si, s_wren=1.
  - RD_PAD: s_addr=(si+sj) mod 256, pt_addr=k.
  - GET_PAD: latch pad=s_rddata and ptb=pt_rddata.
  - WR_CT: ct_addr=k, ct_wrdata=ptb^pad, ct_wren=1. If k==L go to IDLE; else k<=k+1, i<=(i+1) mod 256, go to RD_SI.
- Arithmetic is 8-bit; i, j and si+sj wrap modulo 256. k and L are 8-bit, with L ≤ 255.
- Case i==j: both writes store the same value, and S is unchanged, as the algorithm requires.
- Outputs are decoded from the state and registers. In any state where a port is not listed, the write enables are 0 and the addresses and data hold 0.
- S memory is modified in place. Re-running requires a fresh init/ksa.

## Timing
- Reset values: state=IDLE, rdy=1, all wren=0, all addresses, data, i, j, k, L, si, sj and pad = 0.
- Latency: rdy is low for exactly 3+9·L cycles after the accept edge.
  - L=0 gives 3 cycles.
  - L=255 gives 2298 cycles.
- Exactly one ct write per byte, plus the header write. No S write occurs when L=0.
- Reset mid-operation:
  - Return to IDLE immediately, asynchronously; all outputs take reset values.
  - Partially written ct and S are not restored.
- en held high continuously starts a new run on the first cycle rdy is high after completion.

## Test plan
- Identity S (S[x]=x), pt={2,0xAA,0x55}:
  - Required: ct={2, 0xAA^0x02=0xA8, 0x55^0x05=0x50}.
  - Required: final S[2]=3, S[3]=2.
  - Required: rdy low for 21 cycles.
- L=0, pt={0}:
  - Required: ct[0]=0.
  - Required: s_wren never asserted.
  - Required: rdy low for exactly 3 cycles.
- S prepared by init+ksa with key "Key" (0x4B6579) and pt="Plaintext":
  - Required: ct[0]=9.
  - Required: ct[1..9]=BB F3 16 E8 D9 40 AF 0A D3.
- en pulsed again while busy in the preceding run: no effect, with identical ct and cycle count. Then rdy=1, and a new request is accepted.
- rst_n asserted during the 5th byte of a 9-byte run:
  - Required: rdy=1 and all wren=0 immediately.
  - Required: after re-init, a clean rerun matches the known vector.
- Round trip: encrypt a 3-byte string with key 0x000018, then run the crack/decrypt path on ct. The recovered key is 0x000018 and the plaintext matches.

Source files
------------

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext, XORs each byte with the
// PRGA keystream taken from a pre-scheduled S memory, writes length-prefixed ct.
//
// state   | meaning
// IDLE    | waiting for en, rdy=1
// RD_LEN  | address pt[0]
// GET_LEN | latch plaintext length L
// WR_LEN  | write L to ct[0], set up i/j/k
// RD_SI   | address S[i]
// GET_SI  | latch si, advance j
// RD_SJ   | address S[j]
// GET_SJ  | latch sj
// WR_SI   | S[i] <= sj
// WR_SJ   | S[j] <= si
// RD_PAD  | address S[si+sj] and pt[k]
// GET_PAD | latch pad and plaintext byte
// WR_CT   | ct[k] <= ptb ^ pad, next byte or done
module arc4_encrypt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, GET_LEN, WR_LEN, RD_SI, GET_SI, RD_SJ,
    GET_SJ, WR_SI, WR_SJ, RD_PAD, GET_PAD, WR_CT
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] i, j, k, len, si, sj, pad, ptb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      pad   <= '0;
      ptb   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        GET_LEN: len <= pt_rddata;
        WR_LEN: begin
          j <= 8'd0;
          i <= 8'd1;
          k <= 8'd1;
        end
        GET_SI: begin
          si <= s_rddata;
          j  <= j + s_rddata;
        end
        GET_SJ: sj <= s_rddata;
        GET_PAD: begin
          pad <= s_rddata;
          ptb <= pt_rddata;
        end
        WR_CT: begin
          if (k != len) begin
            k <= k + 8'd1;
            i <= i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = RD_LEN;
      end
      RD_LEN:  state_nxt = GET_LEN;
      GET_LEN: state_nxt = WR_LEN;
      WR_LEN: begin
        ct_wrdata = len;
        ct_wren   = 1'b1;
        state_nxt = (len == 8'd0) ? IDLE : RD_SI;
      end
      RD_SI: begin
        s_addr    = i;
        state_nxt = GET_SI;
      end
      GET_SI: state_nxt = RD_SJ;
      RD_SJ: begin
        s_addr    = j;
        state_nxt = GET_SJ;
      end
      GET_SJ: state_nxt = WR_SI;
      WR_SI: begin
        s_addr    = i;
        s_wrdata  = sj;
        s_wren    = 1'b1;
        state_nxt = WR_SJ;
      end
      // when i==j this rewrites the same location with the value it already holds
      WR_SJ: begin
        s_addr    = j;
        s_wrdata  = si;
        s_wren    = 1'b1;
        state_nxt = RD_PAD;
      end
      RD_PAD: begin
        s_addr    = si + sj;
        pt_addr   = k;
        state_nxt = GET_PAD;
      end
      GET_PAD: state_nxt = WR_CT;
      WR_CT: begin
        ct_addr   = k;
        ct_wrdata = ptb ^ pad;
        ct_wren   = 1'b1;
        state_nxt = (k == len) ? IDLE : RD_SI;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: behavioural S/pt/ct memories plus a plain-arithmetic
// ARC4 (KSA + PRGA) reference model, directed and random runs.
module tb_arc4_encrypt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr, pt_rddata;
  logic [7:0] ct_addr, ct_wrdata;
  logic       ct_wren;

  arc4_encrypt dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] s_init [256];
  logic [7:0] pt_init [256];
  logic       load = 1'b0;
  int         s_writes = 0;
  int         ct_writes = 0;

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (load) begin
      s_mem  <= s_init;
      pt_mem <= pt_init;
      for (int x = 0; x < 256; x++) ct_mem[x] <= 8'hEE;
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_writes++;
      end
      if (ct_wren) begin
        ct_mem[ct_addr] <= ct_wrdata;
        ct_writes++;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // reference model state
  logic [7:0] kb [3];
  logic [7:0] m_s [256];
  logic [7:0] ks [256];
  logic [7:0] exp_ct [256];

  task automatic ksa(input int keylen);
    int jj;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(s_init[x]) + int'(kb[x % keylen])) % 256;
      t = s_init[x]; s_init[x] = s_init[jj]; s_init[jj] = t;
    end
  endtask

  task automatic identity_s();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic model();
    int ii, jj, n;
    logic [7:0] t;
    m_s = s_init;
    n = int'(pt_init[0]);
    exp_ct[0] = pt_init[0];
    ii = 0; jj = 0;
    for (int b = 1; b <= n; b++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(m_s[ii])) % 256;
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      ks[b] = m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256];
      exp_ct[b] = pt_init[b] ^ ks[b];
    end
  endtask

  task automatic set_pt(input string str);
    pt_init[0] = 8'(str.len());
    for (int n = 0; n < str.len(); n++) pt_init[n + 1] = str[n];
  endtask

  task automatic do_load();
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic run(input int pulse_at, input bit hold, output int cyc);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 if (!hold) en = 1'b0;
    cyc = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (rdy) break;
      cyc++;
      if (!hold && t == pulse_at) en = 1'b1;
      else if (!hold) en = 1'b0;
    end
  endtask

  task automatic check_ct(input string tag, input int n);
    int bad = 0;
    for (int x = 0; x <= n; x++) if (ct_mem[x] !== exp_ct[x]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic check_s(input string tag);
    int bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
    check(tag, bad, 0);
  endtask

  logic [7:0] known [9];
  task automatic check_known(input string tag);
    int bad = 0;
    for (int x = 0; x < 9; x++) if (ct_mem[x + 1] !== known[x]) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    int cyc, cyc_ref, sw0, cw0, len, found;
    logic [23:0] rec;
    known = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    // reset state
    #3;
    check("rst_rdy", rdy, 1);
    check("rst_s_wren", s_wren, 0);
    check("rst_ct_wren", ct_wren, 0);
    check("rst_addrs", {s_addr, pt_addr, ct_addr}, 0);
    check("rst_data", {s_wrdata, ct_wrdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // identity S, two bytes
    identity_s();
    pt_init[0] = 8'd2; pt_init[1] = 8'hAA; pt_init[2] = 8'h55;
    model();
    do_load();
    cw0 = ct_writes;
    run(-1, 1'b0, cyc);
    check("id_cycles", cyc, 21);
    check("id_ct0", ct_mem[0], 8'd2);
    check("id_ct1", ct_mem[1], 8'hA8);
    check("id_ct2", ct_mem[2], 8'h50);
    check("id_s2", s_mem[2], 8'd3);
    check("id_s3", s_mem[3], 8'd2);
    check("id_ct_writes", ct_writes - cw0, 3);
    check_s("id_s_model");

    // empty plaintext
    identity_s();
    pt_init[0] = 8'd0;
    do_load();
    sw0 = s_writes; cw0 = ct_writes;
    run(-1, 1'b0, cyc);
    check("l0_cycles", cyc, 3);
    check("l0_ct0", ct_mem[0], 8'd0);
    check("l0_s_writes", s_writes - sw0, 0);
    check("l0_ct_writes", ct_writes - cw0, 1);

    // known vector: key "Key", "Plaintext"
    kb[0] = "K"; kb[1] = "e"; kb[2] = "y";
    ksa(3);
    set_pt("Plaintext");
    model();
    do_load();
    run(-1, 1'b0, cyc_ref);
    check("kv_cycles", cyc_ref, 84);
    check("kv_ct0", ct_mem[0], 8'd9);
    check_known("kv_ct_known");
    check_ct("kv_ct_model", 9);
    check_s("kv_s_model");

    // en pulsed while busy has no effect
    do_load();
    run(20, 1'b0, cyc);
    check("busy_cycles", cyc, cyc_ref);
    check_known("busy_ct_known");
    check("busy_rdy_after", rdy, 1);

    // reset during the 5th byte
    do_load();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (43) @(negedge clk);
    check("mid_busy", rdy, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", rdy, 1);
    check("mid_rst_wren", {s_wren, ct_wren}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load();
    run(-1, 1'b0, cyc);
    check("mid_rerun_cycles", cyc, 84);
    check_known("mid_rerun_ct");

    // en held high restarts right after completion
    do_load();
    run(-1, 1'b1, cyc);
    check("hold_cycles", cyc, 84);
    check_known("hold_ct");
    @(negedge clk);
    check("hold_restart", rdy, 0);
    en = 1'b0;
    for (int t = 0; t < 3000 && !rdy; t++) @(negedge clk);
    check("hold_second_done", rdy, 1);

    // random keys and plaintexts
    for (int r = 0; r < 6; r++) begin
      for (int x = 0; x < 3; x++) kb[x] = 8'($urandom);
      ksa(3);
      len = (r == 5) ? 255 : int'($urandom_range(1, 40));
      pt_init[0] = 8'(len);
      for (int x = 1; x <= len; x++) pt_init[x] = 8'($urandom);
      model();
      do_load();
      run(-1, 1'b0, cyc);
      check($sformatf("rnd%0d_cycles", r), cyc, 3 + 9 * len);
      check_ct($sformatf("rnd%0d_ct", r), len);
      check_s($sformatf("rnd%0d_s", r));
    end

    // round trip: encrypt with key 0x000018, recover key and plaintext from ct
    kb[0] = 8'h00; kb[1] = 8'h00; kb[2] = 8'h18;
    ksa(3);
    set_pt("abc");
    do_load();
    run(-1, 1'b0, cyc);
    found = -1;
    for (int cand = 0; cand < 256 && found < 0; cand++) begin
      kb[2] = 8'(cand);
      ksa(3);
      model();
      if ((ct_mem[1] ^ ks[1]) == "a" && (ct_mem[2] ^ ks[2]) == "b" &&
          (ct_mem[3] ^ ks[3]) == "c") found = cand;
    end
    check("rt_key", found, 32'h18);
    kb[2] = 8'h18;
    ksa(3);
    model();
    rec = {ct_mem[1] ^ ks[1], ct_mem[2] ^ ks[2], ct_mem[3] ^ ks[3]};
    check("rt_plain", rec, 24'h616263);
    check("rt_len", ct_mem[0], 8'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
